// File: rtl/bank_rw_ctrl_k2.sv
// bank_rw_ctrl_k2
// ---------------------------------------------------------------------------
// Consumer end of the radix-2 address path. Each accepted bank/address pair
// is issued as a bank read command one cycle later, then delayed through a
// LAT-deep shift pipeline (LAT = RD_LAT + BF_LAT) and replayed as the in-place
// write-back command. Issued and retired operations are counted; the stage
// completes only after the final write-back of the stage has retired.
//
// Optional feature: define BANK_CONFLICT_CHK_EN to build a sticky bank
// conflict detector (BN0_idx == BN1_idx on an accepted pair). Without it,
// conflict_err is tied to 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   BN_MA_in_en           index pair valid this cycle
//   AGU_done_in           last pair of the stage already presented
//   l_in                  stage number accompanying the pair
//   BN0_idx/BN1_idx       banks of operand 0/1
//   MA0_idx/MA1_idx       in-bank addresses of operand 0/1
//   rd_en, rd_BN*, rd_MA* registered read command
//   wr_en, wr_BN*, wr_MA*, wr_l   registered write-back command
//   busy                  controller not idle
//   stage_done, stage_l   one-cycle completion pulse and its stage number
//   conflict_err          sticky bank-conflict flag
// ---------------------------------------------------------------------------
module bank_rw_ctrl_k2 #(
    parameter int unsigned MA_WIDTH   = 5,
    parameter int unsigned BANK_WIDTH = 4,
    parameter int unsigned D_WIDTH    = 4,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned BF_LAT     = 4,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  BN_MA_in_en,
    input  logic                  AGU_done_in,
    input  logic [D_WIDTH-1:0]    l_in,
    input  logic [BANK_WIDTH-1:0] BN0_idx,
    input  logic [BANK_WIDTH-1:0] BN1_idx,
    input  logic [MA_WIDTH-1:0]   MA0_idx,
    input  logic [MA_WIDTH-1:0]   MA1_idx,
    output logic                  rd_en,
    output logic [BANK_WIDTH-1:0] rd_BN0,
    output logic [BANK_WIDTH-1:0] rd_BN1,
    output logic [MA_WIDTH-1:0]   rd_MA0,
    output logic [MA_WIDTH-1:0]   rd_MA1,
    output logic                  wr_en,
    output logic [BANK_WIDTH-1:0] wr_BN0,
    output logic [BANK_WIDTH-1:0] wr_BN1,
    output logic [MA_WIDTH-1:0]   wr_MA0,
    output logic [MA_WIDTH-1:0]   wr_MA1,
    output logic [D_WIDTH-1:0]    wr_l,
    output logic                  busy,
    output logic                  stage_done,
    output logic [D_WIDTH-1:0]    stage_l,
    output logic                  conflict_err
);

    localparam int unsigned LAT = RD_LAT + BF_LAT;

    // One command slot: valid bit plus the indices and stage that travel with it
    typedef struct packed {
        logic                  vld;
        logic [D_WIDTH-1:0]    l;
        logic [BANK_WIDTH-1:0] bn0;
        logic [BANK_WIDTH-1:0] bn1;
        logic [MA_WIDTH-1:0]   ma0;
        logic [MA_WIDTH-1:0]   ma1;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 accept_c;
    logic                 pipe_busy_c;
    logic                 drained_c;

    cmd_t                 rd_q;
    cmd_t                 pipe_q [LAT];
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [CNT_WIDTH-1:0] wr_cnt;
    logic [D_WIDTH-1:0]   last_wr_l;
    logic                 busy_q;
    logic                 stage_done_q;
    logic [D_WIDTH-1:0]   stage_l_q;

    // Any command still in flight between read issue and write-back
    always_comb begin
        pipe_busy_c = rd_q.vld;
        for (int unsigned i = 0; i < LAT; i++) begin
            pipe_busy_c = pipe_busy_c | pipe_q[i].vld;
        end
    end

    assign drained_c = !pipe_busy_c && (wr_cnt == rd_cnt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and pair acceptance
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                // A pair that arrives together with the done pulse is a
                // one-pair stage and goes straight to draining.
                if (BN_MA_in_en) begin
                    accept_c   = 1'b1;
                    next_state = AGU_done_in ? DRAIN : RUN;
                end
            end
            RUN: begin
                accept_c = BN_MA_in_en;
                if (AGU_done_in) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drained_c) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Read command register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q.vld <= accept_c;
            if (accept_c) begin
                rd_q.l   <= l_in;
                rd_q.bn0 <= BN0_idx;
                rd_q.bn1 <= BN1_idx;
                rd_q.ma0 <= MA0_idx;
                rd_q.ma1 <= MA1_idx;
            end
        end
    end

    // Read-plus-butterfly delay line; the last slot is the write-back command
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rd_q;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Issued/retired counters; cleared when the controller returns to idle
    always_ff @(posedge clk) begin
        if (rst || (state != IDLE && next_state == IDLE)) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_q.vld) begin
                rd_cnt <= rd_cnt + CNT_WIDTH'(1);
            end
            if (pipe_q[LAT-1].vld) begin
                wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Completion reporting: stage number taken from the last retired write
    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_l    <= '0;
            busy_q       <= 1'b0;
            stage_done_q <= 1'b0;
            stage_l_q    <= '0;
        end else begin
            if (pipe_q[LAT-1].vld) begin
                last_wr_l <= pipe_q[LAT-1].l;
            end
            busy_q       <= (next_state != IDLE);
            stage_done_q <= (next_state == DONE);
            if (next_state == DONE) begin
                stage_l_q <= last_wr_l;
            end
        end
    end

`ifdef BANK_CONFLICT_CHK_EN
    logic conflict_q;

    // Sticky until reset; the read itself is issued unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else if (accept_c && (BN0_idx == BN1_idx)) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict_err = conflict_q;
`else
    assign conflict_err = 1'b0;
`endif

    assign rd_en      = rd_q.vld;
    assign rd_BN0     = rd_q.bn0;
    assign rd_BN1     = rd_q.bn1;
    assign rd_MA0     = rd_q.ma0;
    assign rd_MA1     = rd_q.ma1;

    assign wr_en      = pipe_q[LAT-1].vld;
    assign wr_BN0     = pipe_q[LAT-1].bn0;
    assign wr_BN1     = pipe_q[LAT-1].bn1;
    assign wr_MA0     = pipe_q[LAT-1].ma0;
    assign wr_MA1     = pipe_q[LAT-1].ma1;
    assign wr_l       = pipe_q[LAT-1].l;

    assign busy       = busy_q;
    assign stage_done = stage_done_q;
    assign stage_l    = stage_l_q;

endmodule

// File: tb/tb_bank_rw_ctrl_k2.sv
// Testbench for bank_rw_ctrl_k2: directed scenarios followed by random
// traffic, checked every cycle against a schedule of expected events that
// the reference model derives from the accept/complete timing rules.
module tb_bank_rw_ctrl_k2;

    localparam int LAT = 5;
    localparam int N   = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       agu_done;
    logic [3:0] l_in;
    logic [3:0] bn0;
    logic [3:0] bn1;
    logic [4:0] ma0;
    logic [4:0] ma1;

    logic       rd_en;
    logic [3:0] rd_BN0, rd_BN1;
    logic [4:0] rd_MA0, rd_MA1;
    logic       wr_en;
    logic [3:0] wr_BN0, wr_BN1;
    logic [4:0] wr_MA0, wr_MA1;
    logic [3:0] wr_l;
    logic       busy;
    logic       stage_done;
    logic [3:0] stage_l;
    logic       conflict_err;

    bank_rw_ctrl_k2 dut (
        .clk          (clk),
        .rst          (rst),
        .BN_MA_in_en  (en),
        .AGU_done_in  (agu_done),
        .l_in         (l_in),
        .BN0_idx      (bn0),
        .BN1_idx      (bn1),
        .MA0_idx      (ma0),
        .MA1_idx      (ma1),
        .rd_en        (rd_en),
        .rd_BN0       (rd_BN0),
        .rd_BN1       (rd_BN1),
        .rd_MA0       (rd_MA0),
        .rd_MA1       (rd_MA1),
        .wr_en        (wr_en),
        .wr_BN0       (wr_BN0),
        .wr_BN1       (wr_BN1),
        .wr_MA0       (wr_MA0),
        .wr_MA1       (wr_MA1),
        .wr_l         (wr_l),
        .busy         (busy),
        .stage_done   (stage_done),
        .stage_l      (stage_l),
        .conflict_err (conflict_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Expected-event schedule, indexed by cycle
    bit        exp_rd_v  [N];
    bit [31:0] exp_rd_d  [N];
    bit        exp_wr_v  [N];
    bit [31:0] exp_wr_d  [N];
    bit        exp_done  [N];
    bit        exp_busy  [N];
    bit        exp_sl_set[N];
    bit [3:0]  exp_sl_val[N];

    // Reference-model bookkeeping
    bit       m_open;
    bit       m_closed;
    int       m_last_t;
    int       m_D;
    bit [3:0] m_last_l;
    int       m_conf_from = -1;
    bit [3:0] m_stage_l = 4'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    endtask

    // Model: apply the accept / close / completion-time rules for cycle c
    task automatic model(input int c, input bit r, input bit e, input bit d, input bit [3:0] l,
                         input bit [3:0] b0, input bit [3:0] b1, input bit [4:0] a0, input bit [4:0] a1);
        bit acc;
        if (r) begin
            for (int k = c + 1; k < N; k++) begin
                exp_rd_v[k]   = 0;
                exp_wr_v[k]   = 0;
                exp_done[k]   = 0;
                exp_busy[k]   = 0;
                exp_sl_set[k] = 0;
            end
            exp_sl_set[c+1] = 1;
            exp_sl_val[c+1] = 4'd0;
            m_open      = 0;
            m_closed    = 0;
            m_conf_from = -1;
            return;
        end
        if (m_closed && c > m_D) m_closed = 0;
        acc = e && !m_closed;
        if (acc) begin
            m_open = 1;
            exp_rd_v[c+1]     = 1;
            exp_rd_d[c+1]     = {14'd0, b0, b1, a0, a1};
            exp_wr_v[c+1+LAT] = 1;
            exp_wr_d[c+1+LAT] = {10'd0, l, b0, b1, a0, a1};
            m_last_t = c;
            m_last_l = l;
            if (b0 == b1 && m_conf_from < 0) m_conf_from = c + 1;
        end
        if (d && m_open) begin
            m_open   = 0;
            m_closed = 1;
            m_D = (m_last_t + LAT + 3 > c + 2) ? m_last_t + LAT + 3 : c + 2;
            exp_done[m_D]   = 1;
            exp_sl_set[m_D] = 1;
            exp_sl_val[m_D] = m_last_l;
            for (int k = c + 1; k <= m_D; k++) exp_busy[k] = 1;
        end else if (m_open) begin
            exp_busy[c+1] = 1;
        end
    endtask

    task automatic check_cycle(input int c);
        bit conf_exp;
        if (exp_sl_set[c]) m_stage_l = exp_sl_val[c];
`ifdef BANK_CONFLICT_CHK_EN
        conf_exp = (m_conf_from >= 0) && (c >= m_conf_from);
`else
        conf_exp = 1'b0;
`endif
        chk("rd_en", 32'(rd_en), 32'(exp_rd_v[c]));
        if (exp_rd_v[c]) chk("rd_idx", {14'd0, rd_BN0, rd_BN1, rd_MA0, rd_MA1}, exp_rd_d[c]);
        chk("wr_en", 32'(wr_en), 32'(exp_wr_v[c]));
        if (exp_wr_v[c]) chk("wr_idx_l", {10'd0, wr_l, wr_BN0, wr_BN1, wr_MA0, wr_MA1}, exp_wr_d[c]);
        chk("stage_done", 32'(stage_done), 32'(exp_done[c]));
        chk("stage_l", 32'(stage_l), 32'(m_stage_l));
        chk("busy", 32'(busy), 32'(exp_busy[c]));
        chk("conflict_err", 32'(conflict_err), 32'(conf_exp));
    endtask

    task automatic drive(input bit r, input bit e, input bit d, input bit [3:0] l,
                         input bit [3:0] b0, input bit [3:0] b1, input bit [4:0] a0, input bit [4:0] a1);
        rst = r; en = e; agu_done = d; l_in = l;
        bn0 = b0; bn1 = b1; ma0 = a0; ma1 = a1;
        model(cyc, r, e, d, l, b0, b1, a0, a1);
    endtask

    task automatic step(input bit r, input bit e, input bit d, input bit [3:0] l,
                        input bit [3:0] b0, input bit [3:0] b1, input bit [4:0] a0, input bit [4:0] a1);
        @(posedge clk);
        #1;
        cyc++;
        check_cycle(cyc);
        drive(r, e, d, l, b0, b1, a0, a1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0);
    endtask

    // Random-index pair with distinct banks
    task automatic rpair(input bit d, input bit [3:0] l);
        bit [3:0] b0;
        bit [3:0] b1;
        b0 = 4'($urandom);
        b1 = b0 ^ 4'(1 + $urandom_range(0, 14));
        step(0, 1, d, l, b0, b1, 5'($urandom), 5'($urandom));
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            exp_rd_v[k] = 0; exp_wr_v[k] = 0; exp_done[k] = 0;
            exp_busy[k] = 0; exp_sl_set[k] = 0;
            exp_rd_d[k] = 0; exp_wr_d[k] = 0; exp_sl_val[k] = 0;
        end
        m_open = 0;
        m_closed = 0;

        // Reset, then quiet cycles
        drive(1, 0, 0, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0);
        step(1, 0, 0, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0);
        step(1, 0, 0, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0);
        idle(4);

        // Done pulse alone while idle is ignored
        step(0, 0, 1, 4'd7, 4'd0, 4'd0, 5'd0, 5'd0);
        idle(3);

        // Single pair with done in the same cycle, next stage right after stage_done
        step(0, 1, 1, 4'd2, 4'd3, 4'd11, 5'd7, 5'd7);
        idle(8);
        step(0, 1, 1, 4'd9, 4'd1, 4'd2, 5'd3, 5'd4);
        idle(12);

        // Burst of 16 back-to-back pairs
        for (int i = 0; i < 16; i++) rpair(i == 15, 4'd4);
        idle(12);

        // Gapped input, done-limited completion
        rpair(0, 4'd5);
        idle(2);
        rpair(0, 4'd5);
        rpair(0, 4'd6);
        idle(7);
        step(0, 0, 1, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0);
        idle(8);

        // Pairs presented while draining are dropped
        rpair(0, 4'd3);
        rpair(1, 4'd3);
        for (int i = 0; i < 4; i++) rpair(0, 4'd8);
        idle(10);

        // Reset in the middle of a stage
        rpair(0, 4'd1);
        rpair(0, 4'd1);
        rpair(0, 4'd1);
        step(1, 0, 0, 4'd0, 4'd0, 4'd0, 5'd0, 5'd0);
        idle(12);

        // Same bank on both operands
        step(0, 1, 1, 4'd6, 4'd5, 4'd5, 5'd1, 5'd2);
        idle(12);

        // Random traffic including drain-time pairs and rare resets
        for (int i = 0; i < 500; i++) begin
            bit r;
            bit e;
            bit d;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 11) == 0);
            step(r, e, d, 4'($urandom), 4'($urandom), 4'($urandom), 5'($urandom), 5'($urandom));
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
